// File: rtl/bus_board.sv
// Single-master bus board: ROM, RAM, input and output ports behind one request/ready handshake.
// ROM/RAM answer after WAIT_STATES+1 cycles, IO after 1. There is no backpressure: req is sampled only while idle.
module bus_board #(
  parameter int ROM_ADDR_WIDTH = 4,
  parameter int RAM_ADDR_WIDTH = 3,
  parameter int IN_CHANNELS    = 2,
  parameter int OUT_CHANNELS   = 2,
  parameter int WAIT_STATES    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [(2**ROM_ADDR_WIDTH)*8-1:0]  mem,
  input  logic [IN_CHANNELS*8-1:0]          inputs,
  input  logic                              req,
  input  logic                              we,
  input  logic [7:0]                        addr,
  input  logic [7:0]                        wdata,
  output logic                              ready,
  output logic [15:0]                       rdata,
  output logic                              busy,
  output logic [OUT_CHANNELS*8-1:0]         outputs,
  output logic                              fault
);

  localparam int         RAM_BYTES = 2**RAM_ADDR_WIDTH;
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [2:0] WS_LAST   = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] addr_q, wdata_q, in_q;
  logic       we_q;
  logic [7:0] ram    [RAM_BYTES];
  logic [7:0] outreg [OUT_CHANNELS];

  logic [7:0]                cur_addr, cur_in, in_live, out_sel;
  logic                      cur_we;
  logic [4:0]                ch;
  logic                      is_rom, is_ram, is_in, is_out, is_mem;
  logic                      in_ok, out_ok, illegal;
  logic [ROM_ADDR_WIDTH-1:0] rom_i, rom_j;
  logic [RAM_ADDR_WIDTH-1:0] ram_i;
  logic [15:0]               resp_data;

  // Decode the live request while idle, otherwise the captured one.
  always_comb begin
    cur_addr = (state == IDLE) ? addr : addr_q;
    cur_we   = (state == IDLE) ? we : we_q;
    ch       = cur_addr[4:0];
    is_rom   = ~cur_addr[7];
    is_ram   = (cur_addr[7:6] == 2'b10);
    is_in    = (cur_addr[7:5] == 3'b110);
    is_out   = (cur_addr[7:5] == 3'b111);
    is_mem   = is_rom | is_ram;
    rom_i    = cur_addr[ROM_ADDR_WIDTH-1:0];
    rom_j    = rom_i + ROM_ADDR_WIDTH'(1);
    ram_i    = cur_addr[RAM_ADDR_WIDTH-1:0];

    in_live = '0;
    in_ok   = 1'b0;
    for (int c = 0; c < IN_CHANNELS; c++) begin
      if (ch == 5'(c)) begin
        in_live = inputs[c*8 +: 8];
        in_ok   = 1'b1;
      end
    end
    out_sel = '0;
    out_ok  = 1'b0;
    for (int c = 0; c < OUT_CHANNELS; c++) begin
      if (ch == 5'(c)) begin
        out_sel = outreg[c];
        out_ok  = 1'b1;
      end
    end
    cur_in  = (state == IDLE) ? in_live : in_q;
    illegal = (is_rom & cur_we) | (is_in & ~in_ok) | (is_out & ~out_ok);

    resp_data = '0;
    if (!illegal && !cur_we) begin
      if (is_rom)      resp_data = {mem[{rom_j, 3'b000} +: 8], mem[{rom_i, 3'b000} +: 8]};
      else if (is_ram) resp_data = {8'h00, ram[ram_i]};
      else if (is_in)  resp_data = {8'h00, cur_in};
      else             resp_data = {8'h00, out_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      in_q    <= '0;
      we_q    <= 1'b0;
      ready   <= 1'b0;
      rdata   <= '0;
      fault   <= 1'b0;
      for (int i = 0; i < RAM_BYTES; i++)    ram[i]    <= '0;
      for (int c = 0; c < OUT_CHANNELS; c++) outreg[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
            in_q    <= in_live;
            cnt     <= WS_LAST;
            if (is_mem && HAS_WAIT) begin
              state <= WAIT;
            end else begin
              state <= RESP;
              ready <= 1'b1;
              rdata <= resp_data;
              fault <= fault | illegal;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= RESP;
            ready <= 1'b1;
            rdata <= resp_data;
            fault <= fault | illegal;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b0;
          rdata <= '0;
          // Writes land on the edge leaving RESP so a reset before then discards them.
          if (we_q && !illegal) begin
            if (is_ram) begin
              ram[ram_i] <= wdata_q;
            end else if (is_out) begin
              for (int c = 0; c < OUT_CHANNELS; c++)
                if (ch == 5'(c)) outreg[c] <= wdata_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  for (genvar c = 0; c < OUT_CHANNELS; c++) begin : g_out
    assign outputs[c*8 +: 8] = outreg[c];
  end

endmodule

// File: tb/tb_bus_board.sv
// Randomised and directed bench for bus_board against a behavioural address-map model.
module tb_bus_board;

  localparam int WS = 1;
  localparam int NIN = 2;
  localparam int NOUT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] mem;
  logic [15:0]  inputs = '0;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [7:0]   addr = '0;
  logic [7:0]   wdata = '0;
  logic         ready;
  logic [15:0]  rdata;
  logic         busy;
  logic [15:0]  outputs;
  logic         fault;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rom_m [16];
  logic [7:0] ram_m [8];
  logic [7:0] out_m [NOUT];
  logic       fault_m;

  bus_board #(
    .ROM_ADDR_WIDTH(4), .RAM_ADDR_WIDTH(3), .IN_CHANNELS(NIN),
    .OUT_CHANNELS(NOUT), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .mem(mem), .inputs(inputs), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .busy(busy),
    .outputs(outputs), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ram_m[i] = 8'h00;
    for (int i = 0; i < NOUT; i++) out_m[i] = 8'h00;
    fault_m = 1'b0;
  endtask

  // Expected result of one access from the address map; lat = edges after acceptance until ready.
  task automatic model_apply(input logic w, input logic [7:0] a, input logic [7:0] d,
                             input logic [15:0] insnap, output logic [15:0] rd, output int lat);
    int ia = int'(a);
    int chn = ia % 32;
    rd = 16'h0000;
    if (ia < 128) begin
      lat = WS;
      if (w) fault_m = 1'b1;
      else rd = {rom_m[(ia % 16 + 1) % 16], rom_m[ia % 16]};
    end else if (ia < 192) begin
      lat = WS;
      if (w) ram_m[ia % 8] = d;
      else rd = {8'h00, ram_m[ia % 8]};
    end else if (ia < 224) begin
      lat = 0;
      if (chn >= NIN) fault_m = 1'b1;
      else if (!w) rd = {8'h00, insnap[chn*8 +: 8]};
    end else begin
      lat = 0;
      if (chn >= NOUT) fault_m = 1'b1;
      else if (w) out_m[chn] = d;
      else rd = {8'h00, out_m[chn]};
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [15:0] rd, output int lat, output logic rdy_next,
                        output logic [15:0] insnap, output logic busy_acc);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; inputs = 16'($urandom);
    insnap = inputs;
    @(posedge clk); #1;
    busy_acc = busy;
    req = 1'b0; we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    inputs = 16'($urandom);
    lat = 0;
    while (ready !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    @(posedge clk); #1;
    rdy_next = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; addr = 8'hE0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
    vectors++; if (rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    vectors++; if (outputs !== 16'h0) begin miscompares++; $display("FAIL reset_outputs got %h want 0000", outputs); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fault); end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    model_reset();
  endtask

  task automatic test_directed();
    logic [15:0] rd, snap, mrd;
    int lat, mlat;
    logic rn, ba;

    access(1'b0, 8'h02, 8'h00, rd, lat, rn, snap, ba);
    model_apply(1'b0, 8'h02, 8'h00, snap, mrd, mlat);
    vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL rom_read got %h want 1234", rd); end
    vectors++; if (lat !== WS) begin miscompares++; $display("FAIL rom_latency got %0d want %0d", lat, WS); end
    vectors++; if (rn !== 1'b0) begin miscompares++; $display("FAIL ready_one_cycle got %b want 0", rn); end

    access(1'b0, 8'h0F, 8'h00, rd, lat, rn, snap, ba);
    model_apply(1'b0, 8'h0F, 8'h00, snap, mrd, mlat);
    vectors++; if (rd !== 16'h55AA) begin miscompares++; $display("FAIL rom_wrap got %h want 55aa", rd); end

    access(1'b1, 8'h83, 8'h5A, rd, lat, rn, snap, ba);
    model_apply(1'b1, 8'h83, 8'h5A, snap, mrd, mlat);
    vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL ram_write_rdata got %h want 0000", rd); end
    access(1'b0, 8'h8B, 8'h00, rd, lat, rn, snap, ba);
    model_apply(1'b0, 8'h8B, 8'h00, snap, mrd, mlat);
    vectors++; if (rd !== 16'h005A) begin miscompares++; $display("FAIL ram_alias got %h want 005a", rd); end

    access(1'b1, 8'hE1, 8'hC3, rd, lat, rn, snap, ba);
    model_apply(1'b1, 8'hE1, 8'hC3, snap, mrd, mlat);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL io_latency got %0d want 0", lat); end
    vectors++; if (outputs[15:8] !== 8'hC3) begin miscompares++; $display("FAIL out_write got %h want c3", outputs[15:8]); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL legal_no_fault got %b want 0", fault); end

    access(1'b1, 8'h10, 8'h99, rd, lat, rn, snap, ba);
    model_apply(1'b1, 8'h10, 8'h99, snap, mrd, mlat);
    vectors++; if (lat !== WS) begin miscompares++; $display("FAIL rom_write_ready got lat %0d want %0d", lat, WS); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL rom_write_fault got %b want 1", fault); end
    access(1'b0, 8'hC5, 8'h00, rd, lat, rn, snap, ba);
    model_apply(1'b0, 8'hC5, 8'h00, snap, mrd, mlat);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL bad_in_ready got lat %0d want 0", lat); end
    vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL bad_in_rdata got %h want 0000", rd); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_sticky got %b want 1", fault); end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input int period);
    int pulses = 0;
    int exp_pulses = 13 / period;
    logic [15:0] exp_rd;
    int ia = int'(a);
    exp_rd = (ia < 224) ? {8'h00, ram_m[ia % 8]} : {8'h00, out_m[ia % 32]};
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        pulses++;
        vectors++;
        if (rdata !== exp_rd) begin miscompares++; $display("FAIL b2b_rdata got %h want %h", rdata, exp_rd); end
      end else begin
        vectors++;
        if (rdata !== 16'h0) begin miscompares++; $display("FAIL b2b_rdata_idle got %h want 0000", rdata); end
      end
    end
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(posedge clk);
    vectors++;
    if (pulses !== exp_pulses) begin miscompares++; $display("FAIL b2b_pulses addr %h got %0d want %0d", a, pulses, exp_pulses); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd, snap;
    int lat;
    logic rn, ba, seen;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h80; wdata = 8'h77;
    @(posedge clk); #1;
    req = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", seen); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_cleared got %b want 0", fault); end
    vectors++; if (outputs !== 16'h0) begin miscompares++; $display("FAIL outputs_cleared got %h want 0000", outputs); end
    access(1'b0, 8'h80, 8'h00, rd, lat, rn, snap, ba);
    vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL abort_no_write got %h want 0000", rd); end
  endtask

  task automatic test_random(input int n);
    logic [15:0] rd, snap, mrd;
    int lat, mlat;
    logic rn, ba, w;
    logic [7:0] a, d;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      access(w, a, d, rd, lat, rn, snap, ba);
      model_apply(w, a, d, snap, mrd, mlat);
      vectors++; if (rd !== mrd) begin miscompares++; $display("FAIL rand_rdata we=%b addr=%h got %h want %h", w, a, rd, mrd); end
      vectors++; if (lat !== mlat) begin miscompares++; $display("FAIL rand_latency addr=%h got %0d want %0d", a, lat, mlat); end
      vectors++; if (ba !== 1'b1) begin miscompares++; $display("FAIL rand_busy addr=%h got %b want 1", a, ba); end
      vectors++; if (rn !== 1'b0 || rdata !== 16'h0) begin miscompares++; $display("FAIL rand_after_resp got ready %b rdata %h want 0 0000", rn, rdata); end
      vectors++; if (fault !== fault_m) begin miscompares++; $display("FAIL rand_fault addr=%h got %b want %b", a, fault, fault_m); end
      vectors++; if (outputs !== {out_m[1], out_m[0]}) begin miscompares++; $display("FAIL rand_outputs got %h want %h", outputs, {out_m[1], out_m[0]}); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_m[i] = 8'($urandom);
    rom_m[0] = 8'h55; rom_m[2] = 8'h34; rom_m[3] = 8'h12; rom_m[15] = 8'hAA;
    for (int i = 0; i < 16; i++) mem[i*8 +: 8] = rom_m[i];
    model_reset();

    test_reset();
    test_directed();
    test_reset_abort();
    test_random(40);
    test_back_to_back(8'h85, WS + 2);
    test_back_to_back(8'hE0, 2);
    test_random(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
